// File: rtl/audio_table_loader.sv
// Purpose: streams 16-bit PCM samples from a valid/ready source into the custom-wave table.
// Latency: a sample accepted in cycle c reaches the table in cycle c+2 if the FIFO is empty and there is no stall.
// Backpressure: sample_ready_o drops when the FIFO is full and nothing pops; stall_i freezes writes only.
//
// Ports: clk_i/rst_n_i (async active-low); start_i/abort_i job control; base_addr_i/length_i
// are sampled on start; stall_i holds table writes; sample_valid_i/sample_i/sample_ready_o is
// the input stream; write_table_o/table_addr_o/pcm_o is the table write port; busy_o/done_o/
// error_o/count_o report job status.

// Generic FIFO. It allows a push and a pop in the same cycle while full, because the pop frees
// the head slot at the same edge that the push fills it.
module sync_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push_vld,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic         full,
    output logic         empty
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   level;

    assign full     = (level == (PW+1)'(DEPTH));
    assign empty    = (level == '0);
    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push_vld) wr_ptr <= wr_ptr + 1'b1;
            if (pop)      rd_ptr <= rd_ptr + 1'b1;
            if (push_vld && !pop)      level <= level + 1'b1;
            else if (!push_vld && pop) level <= level - 1'b1;
        end
    end

    // The storage array has no reset. Only the pointers define which entries are valid.
    always_ff @(posedge clk) begin
        if (push_vld && !clr) mem[wr_ptr] <= push_dat;
    end
endmodule

module audio_table_loader #(
    parameter int TABLE_DEPTH = 1024,
    parameter int ADDR_W      = 10,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              start_i,
    input  logic              abort_i,
    input  logic [ADDR_W-1:0] base_addr_i,
    input  logic [ADDR_W:0]   length_i,
    input  logic              stall_i,
    input  logic              sample_valid_i,
    input  logic [15:0]       sample_i,
    output logic              sample_ready_o,
    output logic              write_table_o,
    output logic [ADDR_W-1:0] table_addr_o,
    output logic [15:0]       pcm_o,
    output logic              busy_o,
    output logic              done_o,
    output logic              error_o,
    output logic [ADDR_W:0]   count_o
);
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_DRAIN, ST_DONE} state_t;

    localparam logic [ADDR_W:0] MAX_LEN = (ADDR_W+1)'(TABLE_DEPTH);

    state_t            state;
    logic [ADDR_W-1:0] base_q;
    logic [ADDR_W:0]   length_q;
    logic [ADDR_W:0]   accepted_q;
    logic              fifo_full;
    logic              fifo_empty;
    logic [15:0]       fifo_head;
    logic              in_job;
    logic              push;
    logic              pop;

    assign in_job = (state == ST_LOAD) || (state == ST_DRAIN);

    // An abort in this cycle suppresses the pop. This keeps write_table_o low on the cycle after the abort.
    assign pop = in_job && !fifo_empty && !stall_i && !abort_i;

    // When the FIFO is full, a pop in the same cycle still lets a new sample in.
    assign sample_ready_o = (state == ST_LOAD) && !abort_i && (accepted_q < length_q) &&
                            (!fifo_full || pop);
    assign push = sample_valid_i && sample_ready_o;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (16)
    ) u_fifo (
        .clk      (clk_i),
        .rst_n    (rst_n_i),
        .clr      (abort_i),
        .push_vld (push),
        .push_dat (sample_i),
        .pop      (pop),
        .head_dat (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= ST_IDLE;
            base_q        <= '0;
            length_q      <= '0;
            accepted_q    <= '0;
            count_o       <= '0;
            write_table_o <= 1'b0;
            table_addr_o  <= '0;
            pcm_o         <= '0;
            busy_o        <= 1'b0;
            done_o        <= 1'b0;
            error_o       <= 1'b0;
        end else begin
            write_table_o <= 1'b0;
            done_o        <= 1'b0;
            error_o       <= 1'b0;

            // Write stage. The address wraps because the sum is truncated to ADDR_W bits.
            if (pop) begin
                write_table_o <= 1'b1;
                table_addr_o  <= base_q + count_o[ADDR_W-1:0];
                pcm_o         <= fifo_head;
                count_o       <= count_o + 1'b1;
            end

            if (abort_i) begin
                state  <= ST_IDLE;
                busy_o <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (start_i) begin
                            if (length_i != '0 && length_i <= MAX_LEN) begin
                                base_q     <= base_addr_i;
                                length_q   <= length_i;
                                accepted_q <= '0;
                                count_o    <= '0;
                                busy_o     <= 1'b1;
                                state      <= ST_LOAD;
                            end else begin
                                error_o <= 1'b1;
                            end
                        end
                    end
                    ST_LOAD: begin
                        if (push) begin
                            accepted_q <= accepted_q + 1'b1;
                            if (accepted_q + 1'b1 == length_q) state <= ST_DRAIN;
                        end
                    end
                    ST_DRAIN: begin
                        // The final write has been issued once count_o reaches the job length.
                        if (fifo_empty && count_o == length_q) begin
                            state  <= ST_DONE;
                            done_o <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= ST_IDLE;
                        busy_o <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_audio_table_loader.sv
// Purpose: directed checks of audio_table_loader (ordering, wrap, stall, errors, abort, reset, random stress).
// Latency: inputs are driven 1 ns after each rising edge; writes and pulses are logged on the falling edge.
// Backpressure: the source holds each sample until it sees valid && ready on the falling edge.
module tb_audio_table_loader;
    logic        clk_i = 1'b0;
    logic        rst_n_i;
    logic        start_i, abort_i, stall_i, sample_valid_i;
    logic [9:0]  base_addr_i;
    logic [10:0] length_i;
    logic [15:0] sample_i;
    logic        sample_ready_o, write_table_o, busy_o, done_o, error_o;
    logic [9:0]  table_addr_o;
    logic [15:0] pcm_o;
    logic [10:0] count_o;

    int n_checks = 0;
    int n_errors = 0;

    audio_table_loader dut (
        .clk_i          (clk_i),
        .rst_n_i        (rst_n_i),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .base_addr_i    (base_addr_i),
        .length_i       (length_i),
        .stall_i        (stall_i),
        .sample_valid_i (sample_valid_i),
        .sample_i       (sample_i),
        .sample_ready_o (sample_ready_o),
        .write_table_o  (write_table_o),
        .table_addr_o   (table_addr_o),
        .pcm_o          (pcm_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .error_o        (error_o),
        .count_o        (count_o)
    );

    always #5 clk_i = ~clk_i;

    // Event logs. Only the processes below write them; tests read them relative to saved sizes.
    int          cyc = 0;
    logic [9:0]  wr_addr_q[$];
    logic [15:0] wr_dat_q[$];
    int          wr_cyc_q[$];
    int          acc_cyc_q[$];
    int          done_cnt = 0;
    int          done_cyc = 0;
    int          err_cnt  = 0;

    always @(posedge clk_i) cyc <= cyc + 1;

    always @(negedge clk_i) begin
        if (write_table_o) begin
            wr_addr_q.push_back(table_addr_o);
            wr_dat_q.push_back(pcm_o);
            wr_cyc_q.push_back(cyc);
        end
        if (sample_valid_i && sample_ready_o) acc_cyc_q.push_back(cyc);
        if (done_o) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (error_o) err_cnt = err_cnt + 1;
    end

    logic [15:0] src_q[$];
    bit          stop_src = 1'b0;
    bit          src_done = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk_i);
        #1;
    endtask

    task automatic start_job(input int base, input int len);
        base_addr_i = 10'(base);
        length_i    = 11'(len);
        start_i     = 1'b1;
        tick(1);
        start_i     = 1'b0;
    endtask

    // Feeds src_q in order. A sample advances only after a falling edge shows it was accepted.
    task automatic run_source(input int max_cyc, input bit gaps);
        int  idx = 0;
        int  n   = 0;
        bit  acc;
        while (idx < src_q.size() && n < max_cyc && !stop_src) begin
            sample_valid_i = !(gaps && $urandom_range(0, 2) == 0);
            sample_i       = src_q[idx];
            @(negedge clk_i);
            acc = sample_valid_i && sample_ready_o;
            @(posedge clk_i);
            #1;
            if (acc) idx++;
            n++;
        end
        sample_valid_i = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0, input int max_cyc);
        int n = 0;
        while (done_cnt == d0 && n < max_cyc) begin
            tick(1);
            n++;
        end
        check({tag, "_done_once"}, done_cnt - d0, 1);
    endtask

    task automatic check_writes(input string tag, input int wb, input int base, input int n);
        check({tag, "_nwr"}, wr_addr_q.size() - wb, n);
        for (int i = 0; i < n; i++) begin
            if (wb + i < wr_addr_q.size()) begin
                check({tag, "_addr"}, wr_addr_q[wb+i], (base + i) % 1024);
                check({tag, "_dat"}, wr_dat_q[wb+i], src_q[i]);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int wb, ab, d0, e0, n;

        rst_n_i = 1'b0; start_i = 1'b0; abort_i = 1'b0; stall_i = 1'b0;
        sample_valid_i = 1'b0; sample_i = '0; base_addr_i = '0; length_i = '0;

        // Reset values
        #12;
        check("rst_wr", write_table_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_err", error_o, 0);
        check("rst_cnt", count_o, 0);
        check("rst_rdy", sample_ready_o, 0);
        check("rst_addr", table_addr_o, 0);
        check("rst_pcm", pcm_o, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick(1);

        // Back-to-back load at base 0
        src_q = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        wb = wr_addr_q.size(); ab = acc_cyc_q.size(); d0 = done_cnt;
        start_job(0, 4);
        check("t1_busy", busy_o, 1);
        run_source(50, 1'b0);
        wait_done("t1", d0, 40);
        check_writes("t1", wb, 0, 4);
        if (wr_cyc_q.size() > wb + 3 && acc_cyc_q.size() > ab) begin
            check("t1_latency", wr_cyc_q[wb] - acc_cyc_q[ab], 2);
            check("t1_done_after_last", done_cyc - wr_cyc_q[wb+3], 1);
        end
        check("t1_count", count_o, 4);
        tick(1);
        check("t1_busy_after", busy_o, 0);

        // Address wrap from 1022
        src_q = '{16'hA000, 16'hA001, 16'hA002, 16'hA003};
        wb = wr_addr_q.size(); d0 = done_cnt;
        start_job(1022, 4);
        run_source(50, 1'b0);
        wait_done("t2", d0, 40);
        check_writes("t2", wb, 1022, 4);
        tick(2);
        check("t2_done_once_total", done_cnt - d0, 1);
        check("t2_busy_after", busy_o, 0);

        // Stall fills the FIFO to full, then the release gives a run of consecutive writes
        src_q.delete();
        for (int i = 0; i < 12; i++) src_q.push_back(16'h5000 + 16'(i));
        wb = wr_addr_q.size(); ab = acc_cyc_q.size(); d0 = done_cnt;
        stall_i = 1'b1;
        start_job(512, 12);
        fork
            run_source(300, 1'b0);
            begin
                tick(20);
                check("t3_acc_stalled", acc_cyc_q.size() - ab, 8);
                check("t3_wr_stalled", wr_addr_q.size() - wb, 0);
                check("t3_rdy_full", sample_ready_o, 0);
                stall_i = 1'b0;
            end
        join
        wait_done("t3", d0, 60);
        check_writes("t3", wb, 512, 12);
        for (int i = 1; i < 12; i++) begin
            if (wr_cyc_q.size() > wb + i)
                check("t3_consecutive", wr_cyc_q[wb+i] - wr_cyc_q[wb+i-1], 1);
        end
        tick(1);

        // Rejected start lengths
        e0 = err_cnt;
        start_job(0, 0);
        check("t4_err_len0", error_o, 1);
        check("t4_busy_len0", busy_o, 0);
        tick(1);
        check("t4_err_pulse0", error_o, 0);
        start_job(0, 1025);
        check("t4_err_len1025", error_o, 1);
        check("t4_busy_len1025", busy_o, 0);
        tick(1);
        check("t4_err_pulse1025", error_o, 0);
        check("t4_err_count", err_cnt - e0, 2);

        // Abort after three writes, then restart
        src_q.delete();
        for (int i = 0; i < 10; i++) src_q.push_back(16'hC000 + 16'(i));
        wb = wr_addr_q.size(); d0 = done_cnt;
        start_job(100, 10);
        fork
            run_source(200, 1'b0);
            begin
                n = 0;
                while (count_o != 3 && n < 60) begin
                    tick(1);
                    n++;
                end
                check("t5_reach3", count_o, 3);
                abort_i  = 1'b1;
                stop_src = 1'b1;
                tick(1);
                abort_i = 1'b0;
                check("t5_wr_after_abort", write_table_o, 0);
                check("t5_busy_after_abort", busy_o, 0);
                check("t5_rdy_after_abort", sample_ready_o, 0);
            end
        join
        tick(5);
        stop_src = 1'b0;
        check("t5_count_kept", count_o, 3);
        check("t5_no_done", done_cnt - d0, 0);
        check("t5_writes", wr_addr_q.size() - wb, 3);
        src_q = '{16'h0BB0, 16'h0BB1};
        wb = wr_addr_q.size(); d0 = done_cnt;
        start_job(500, 2);
        run_source(50, 1'b0);
        wait_done("t5b", d0, 40);
        check_writes("t5b", wb, 500, 2);
        check("t5b_count", count_o, 2);
        tick(1);

        // Reset while in DRAIN with a write on the port
        src_q = '{16'hD000, 16'hD001, 16'hD002, 16'hD003};
        stall_i = 1'b1;
        start_job(300, 4);
        run_source(50, 1'b0);
        stall_i = 1'b0;
        tick(1);
        stall_i = 1'b1;
        check("t6_pre_rst_wr", write_table_o, 1);
        check("t6_pre_rst_busy", busy_o, 1);
        rst_n_i = 1'b0;
        #1;
        check("t6_rst_wr", write_table_o, 0);
        check("t6_rst_busy", busy_o, 0);
        check("t6_rst_cnt", count_o, 0);
        check("t6_rst_addr", table_addr_o, 0);
        check("t6_rst_pcm", pcm_o, 0);
        check("t6_rst_rdy", sample_ready_o, 0);
        stall_i = 1'b0;
        @(negedge clk_i);
        rst_n_i = 1'b1;
        tick(1);

        // Random valid gaps and random stalls across the wrap point
        src_q.delete();
        for (int i = 0; i < 20; i++) src_q.push_back(16'($urandom));
        wb = wr_addr_q.size(); d0 = done_cnt;
        src_done = 1'b0;
        start_job(1010, 20);
        fork
            begin
                run_source(400, 1'b1);
                src_done = 1'b1;
            end
            begin
                while (!src_done) begin
                    stall_i = ($urandom_range(0, 3) == 0);
                    tick(1);
                end
                stall_i = 1'b0;
            end
        join
        wait_done("t7", d0, 100);
        check_writes("t7", wb, 1010, 20);
        check("t7_count", count_o, 20);
        tick(1);
        check("t7_busy_after", busy_o, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
